// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator for a word-addressed single-port memory.
// Handles byte/half/word accesses with sign/zero-extension and read-modify-write sub-word stores.
module lsu_mem_master #(
    parameter int IDX_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t           r_state, w_next;
    logic             r_we, r_err;
    logic [2:0]       r_f3;
    logic [IDX_W+1:0] r_addr;
    logic [31:0]      r_wdata, r_old, r_rdata;
    logic             w_err, w_f3_bad, w_misal, w_range;
    logic [4:0]       w_sh;
    logic [31:0]      w_lane, w_ext, w_mask, w_merge;

    always_comb begin
        w_f3_bad = req_we ? (req_funct3 > 3'd2) : (req_funct3[1:0] == 2'b11 || req_funct3 == 3'b110);
        w_misal  = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
        w_range  = |req_addr[31:IDX_W+2];
        w_err    = w_f3_bad || w_misal || w_range;
    end

    // Accesses are aligned, so the byte offset is also the lane shift for halves and words.
    always_comb begin
        w_sh    = {r_addr[1:0], 3'b000};
        w_lane  = mem_rd >> w_sh;
        w_ext   = r_f3[1:0] == 2'b00 ? {{24{~r_f3[2] & w_lane[7]}}, w_lane[7:0]} :
                  r_f3[1:0] == 2'b01 ? {{16{~r_f3[2] & w_lane[15]}}, w_lane[15:0]} : w_lane;
        w_mask  = (r_f3[1:0] == 2'b00 ? 32'h0000_00FF : r_f3[1:0] == 2'b01 ? 32'h0000_FFFF : 32'hFFFF_FFFF) << w_sh;
        w_merge = (r_old & ~w_mask) | ((r_wdata << w_sh) & w_mask);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = !req_valid ? IDLE : w_err ? RESP :
                              (!req_we || req_funct3[1:0] != 2'b10) ? READ : WRITE;
            READ:    w_next = r_we ? WRITE : RESP;
            WRITE:   w_next = RESP;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = r_state == IDLE;
        resp_valid = r_state == RESP;
        mem_we     = r_state == WRITE;
        mem_addr   = (r_state == READ || r_state == WRITE) ? {{(32-IDX_W){1'b0}}, r_addr[IDX_W+1:2]} : 32'd0;
        mem_wd     = r_state == WRITE ? w_merge : 32'd0;
        resp_rdata = r_rdata;
        resp_err   = r_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_f3    <= 3'd0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_old   <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && req_valid) begin
                r_we    <= req_we;
                r_f3    <= req_funct3;
                r_addr  <= req_addr[IDX_W+1:0];
                r_wdata <= req_wdata;
                if (w_err) begin
                    r_rdata <= 32'd0;
                    r_err   <= 1'b1;
                end
            end
            if (r_state == READ) begin
                r_old <= mem_rd;
                if (!r_we) begin
                    r_rdata <= w_ext;
                    r_err   <= 1'b0;
                end
            end
            if (r_state == WRITE) begin
                r_rdata <= 32'd0;
                r_err   <= 1'b0;
            end
        end
    end
endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator between the datapath and the word-addressed, single-port data memory.
- The memory reads combinationally from its address and writes on the clock edge.
- Accepts one byte/half/word load or store per handshake and converts the byte address to a word index.
- Performs read-modify-write for sub-word stores, sign/zero-extends loads, and flags misaligned or out-of-range accesses without touching memory.

Parameters:
- IDX_W, 5, width of the memory word index; memory depth = 2**IDX_W words.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request; high only in IDLE
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RISC-V funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load result; 0 for stores and errors
- resp_err  output  1  misaligned, out-of-range or illegal funct3; valid with resp_valid
- mem_addr  output  32  word index to memory: zero-extended, value = addr[IDX_W+1:2]
- mem_wd  output  32  write word to memory
- mem_we  output  1  memory write enable
- mem_rd  input  32  combinational read word from memory

Behaviour:
- Reset (async, rst=1): state=IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wd=0. Reset mid-transaction abandons it. No response is issued. If mem_we was high, it drops immediately.
- Handshake: a request is accepted when req_valid & req_ready at a rising edge. All request fields are captured into registers at that edge. req_ready=0 in every state except IDLE.
- There is no response backpressure: resp_valid is high for exactly one cycle in RESP.
- States: IDLE, READ, WRITE, RESP.
- Check at accept, from the captured fields:
  - err = misaligned (half with addr[0]=1; word with addr[1:0]!=0), or addr[31:IDX_W+2]!=0, or illegal funct3 (load 011/110/111; store other than 000/001/010).
  - Any err: IDLE->RESP, resp_err=1, no memory access. Response one cycle after accept.
- Load: IDLE->READ->RESP.
  - In READ, mem_addr = captured index. mem_rd is registered at the end of READ.
  - In RESP, resp_rdata = the selected lane extended per funct3:
    - Byte lane = addr[1:0]*8.
    - Half lane = addr[1]*16.
    - LB/LH sign-extend; LBU/LHU zero-extend.
  - Response at accept+2.
- Store word: IDLE->WRITE->RESP. In WRITE, mem_we=1 and mem_wd=req_wdata. Response at accept+2.
- Store byte/half: IDLE->READ->WRITE->RESP.
  - In READ, the old word is captured.
  - In WRITE, mem_wd = old word with only the addressed lane replaced by wdata[7:0] or wdata[15:0]; other bits are unchanged.
  - Response at accept+3.
- mem_we is high only in WRITE, exactly one cycle per store. mem_addr holds the captured index from READ through WRITE.
- RESP->IDLE unconditionally. req_ready rises the cycle after the resp_valid pulse. Back-to-back requests therefore have a minimum spacing of resp latency + 1.
- resp_rdata and resp_err are registered. They hold their values until the next RESP.
- Index wraps: none. Out-of-range requests are reported as errors, never aliased.

Test Plan:
- Reset mid-READ of an SB → all outputs return to reset values immediately; no mem_we pulse occurs; the next request is accepted normally.
- SW addr 0x0000_0008, wdata 0xDEADBEEF → mem_we for one cycle with mem_addr=2, mem_wd=0xDEADBEEF; resp_valid at accept+2, resp_err=0. Then LW 0x8 → resp_rdata=0xDEADBEEF at accept+2.
- Memory word 2 = 0xDEADBEEF:
  - SB addr 0x9, wdata 0x12 → mem_wd=0xDEAD12EF at accept+2, resp at accept+3.
  - SH addr 0xA, wdata 0x5566 → mem_wd=0x556612EF.
- Word 2 = 0x80FF7F01:
  - LB 0x8 → 0x00000001; LB 0x9 → 0x0000007F; LB 0xA → 0xFFFFFFFF.
  - LBU 0xB → 0x00000080; LH 0xA → 0xFFFF80FF; LHU 0xA → 0x000080FF.
- Errors, each with resp_valid and resp_err=1 at accept+1 and no mem_we:
  - LW 0x6; SH 0x3; LW 0x80 (IDX_W=5); load funct3=011.
- Throughput: hold req_valid high with 3 LWs → req_ready low during each transaction; each accept occurs the cycle after the previous resp_valid; all three results are correct and in order.
